// File: rtl/cache_tag_engine.sv
// Set-associative tag engine: tag lookup, victim choice (FIFO/LRU), write-through/write-back
// dirty tracking and saturating statistics, one request in flight at a time.
module cache_tag_engine #(
    parameter int ADDR_W      = 48,
    parameter int BLOCK_BYTES = 64,
    parameter int NUM_SETS    = 64,
    parameter int NUM_WAYS    = 4,
    parameter int CNT_W       = 16,
    localparam int OB    = $clog2(BLOCK_BYTES),
    localparam int IB    = $clog2(NUM_SETS),
    localparam int WB    = $clog2(NUM_WAYS),
    localparam int TAG_W = ADDR_W - OB - IB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic              replace_policy,
    input  logic              write_policy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [WB-1:0]     resp_way,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_evict_tag,
    output logic              resp_evict_dirty,
    output logic [CNT_W-1:0]  num_reads,
    output logic [CNT_W-1:0]  num_writes,
    output logic [CNT_W-1:0]  num_hits,
    output logic [CNT_W-1:0]  num_misses,
    output logic [CNT_W-1:0]  num_mem_writes
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IB-1:0]    idx;
        logic             write;
        logic             lru;
        logic             wb;
    } req_t;

    logic [1:0]       state;
    req_t             rq;
    logic [TAG_W-1:0] tag_mem   [NUM_SETS][NUM_WAYS];
    logic [WB-1:0]    age_mem   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_mem [NUM_SETS];
    logic [WB-1:0]    hit_age_q;

    logic          lk_hit, inv_found;
    logic [WB-1:0] lk_hit_way, inv_way, old_way, old_age, victim;
    logic [1:0]    mw_inc;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    // Victim: lowest invalid way, else the oldest (ages are distinct once the set is full).
    always_comb begin
        lk_hit     = 1'b0;
        lk_hit_way = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        old_way    = '0;
        old_age    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_mem[rq.idx][w] && tag_mem[rq.idx][w] == rq.tag) begin
                lk_hit     = 1'b1;
                lk_hit_way = WB'(w);
            end
            if (!valid_mem[rq.idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WB'(w);
            end
            if (age_mem[rq.idx][w] > old_age) begin
                old_age = age_mem[rq.idx][w];
                old_way = WB'(w);
            end
        end
        victim = inv_found ? inv_way : old_way;
    end

    assign mw_inc = {1'b0, rq.write & ~rq.wb} + {1'b0, resp_evict & resp_evict_dirty};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-1){1'b0}}, n};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            rq               <= '0;
            hit_age_q        <= '0;
            resp_hit         <= 1'b0;
            resp_way         <= '0;
            resp_evict       <= 1'b0;
            resp_evict_tag   <= '0;
            resp_evict_dirty <= 1'b0;
            num_reads        <= '0;
            num_writes       <= '0;
            num_hits         <= '0;
            num_misses       <= '0;
            num_mem_writes   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_mem[s][w] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    rq    <= '{tag: req_addr[ADDR_W-1:OB+IB], idx: req_addr[OB+IB-1:OB],
                               write: req_write, lru: replace_policy, wb: write_policy};
                    state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    resp_hit         <= lk_hit;
                    resp_way         <= lk_hit ? lk_hit_way : victim;
                    resp_evict       <= !lk_hit && valid_mem[rq.idx][victim];
                    resp_evict_tag   <= lk_hit ? '0 : tag_mem[rq.idx][victim];
                    resp_evict_dirty <= !lk_hit && valid_mem[rq.idx][victim] && dirty_mem[rq.idx][victim];
                    hit_age_q        <= age_mem[rq.idx][lk_hit_way];
                    state            <= S_UPDATE;
                end
                S_UPDATE: begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (WB'(w) == resp_way) begin
                            if (!resp_hit || rq.lru) age_mem[rq.idx][w] <= '0;
                            if (!resp_hit) begin
                                valid_mem[rq.idx][w] <= 1'b1;
                                dirty_mem[rq.idx][w] <= rq.wb & rq.write;
                            end else if (rq.write) begin
                                dirty_mem[rq.idx][w] <= rq.wb;
                            end
                        end else if (valid_mem[rq.idx][w] &&
                                     (!resp_hit || (rq.lru && age_mem[rq.idx][w] < hit_age_q))) begin
                            age_mem[rq.idx][w] <= age_mem[rq.idx][w] + 1'b1;
                        end
                    end
                    num_reads      <= sat_add(num_reads,  {1'b0, ~rq.write});
                    num_writes     <= sat_add(num_writes, {1'b0, rq.write});
                    num_hits       <= sat_add(num_hits,   {1'b0, resp_hit});
                    num_misses     <= sat_add(num_misses, {1'b0, ~resp_hit});
                    num_mem_writes <= sat_add(num_mem_writes, mw_inc);
                    state          <= S_RESP;
                end
                default: if (resp_ready) state <= S_IDLE;
            endcase
        end
    end

    // Tags need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (!reset && state == S_UPDATE && !resp_hit)
            tag_mem[rq.idx][resp_way] <= rq.tag;
    end
endmodule

// File: tb/tb_cache_tag_engine.sv
// Directed-vector bench for cache_tag_engine: hit/miss, FIFO vs LRU eviction, dirty tracking,
// response hold, mid-request reset and counter saturation.
module tb_cache_tag_engine;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, replace_policy, write_policy;
    logic [47:0] req_addr;
    logic        resp_valid, resp_ready, resp_hit, resp_evict, resp_evict_dirty;
    logic [1:0]  resp_way;
    logic [35:0] resp_evict_tag;
    logic [CW-1:0] num_reads, num_writes, num_hits, num_misses, num_mem_writes;

    cache_tag_engine #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .replace_policy(replace_policy), .write_policy(write_policy),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
        .resp_evict_dirty(resp_evict_dirty),
        .num_reads(num_reads), .num_writes(num_writes), .num_hits(num_hits),
        .num_misses(num_misses), .num_mem_writes(num_mem_writes)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    logic        r_hit, r_evict, r_edirty;
    logic [1:0]  r_way;
    logic [35:0] r_etag;
    int          r_lat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_addr = '0; req_write = 1'b0; replace_policy = 1'b0; write_policy = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Accepts one request and waits for the response without consuming it.
    task automatic issue(input logic [47:0] a, input logic w, input logic rp, input logic wp);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1; req_addr = a; req_write = w; replace_policy = rp; write_policy = wp;
        @(posedge clk); #1;
        // scramble request inputs: the in-flight request must not see them
        req_valid = 1'b0; req_addr = '1; req_write = ~w; replace_policy = ~rp; write_policy = ~wp;
        r_lat = 1;
        while (!resp_valid && r_lat < 20) begin @(posedge clk); #1; r_lat++; end
        if (!resp_valid) chk("resp_timeout", 0, 1);
        r_hit = resp_hit; r_way = resp_way; r_evict = resp_evict;
        r_etag = resp_evict_tag; r_edirty = resp_evict_dirty;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_req(input logic [47:0] a, input logic w, input logic rp, input logic wp);
        issue(a, w, rp, wp);
        finish_resp();
    endtask

    initial begin
        do_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_fields", {resp_hit, resp_evict, resp_evict_dirty, resp_way, resp_evict_tag}, 0);
        chk("rst_counters", {num_reads, num_writes, num_hits, num_misses, num_mem_writes}, 0);

        // read miss then same-line hit
        issue(48'h1000, 0, 0, 0);
        chk("lat", r_lat, 3);
        chk("r1_hit", r_hit, 0);
        chk("r1_way", r_way, 0);
        chk("r1_evict", r_evict, 0);
        finish_resp();
        chk("ready_after_hs", req_ready, 1);
        do_req(48'h1010, 0, 0, 0);
        chk("r2_hit", r_hit, 1);
        chk("r2_way", r_way, 0);
        chk("r2_cnt", {num_reads, num_hits, num_misses, num_writes}, {4'd2, 4'd1, 4'd1, 4'd0});

        // FIFO replacement
        do_reset();
        do_req(48'h1000, 0, 0, 0); do_req(48'h2000, 0, 0, 0);
        do_req(48'h3000, 0, 0, 0); do_req(48'h4000, 0, 0, 0);
        chk("fifo_fill4_way", r_way, 3);
        do_req(48'h1000, 0, 0, 0);
        chk("fifo_5_hit", r_hit, 1);
        do_req(48'h5000, 0, 0, 0);
        chk("fifo_6_evict", {r_hit, r_evict, r_way}, {1'b0, 1'b1, 2'd0});
        chk("fifo_6_etag", r_etag, 36'h1);
        do_req(48'h1000, 0, 0, 0);
        chk("fifo_7_hit", r_hit, 0);
        chk("fifo_7_etag", r_etag, 36'h2);

        // LRU replacement
        do_reset();
        do_req(48'h1000, 0, 1, 0); do_req(48'h2000, 0, 1, 0);
        do_req(48'h3000, 0, 1, 0); do_req(48'h4000, 0, 1, 0);
        do_req(48'h1000, 0, 1, 0);
        chk("lru_5_hit", r_hit, 1);
        do_req(48'h5000, 0, 1, 0);
        chk("lru_6_evict", {r_hit, r_evict, r_way}, {1'b0, 1'b1, 2'd1});
        chk("lru_6_etag", r_etag, 36'h2);
        do_req(48'h1000, 0, 1, 0);
        chk("lru_7_hit", {r_hit, r_way}, {1'b1, 2'd0});

        // write-back: dirty eviction
        do_reset();
        do_req(48'h1000, 1, 0, 1);
        chk("wb_wr_memw", num_mem_writes, 0);
        do_req(48'h2000, 0, 0, 1); do_req(48'h3000, 0, 0, 1);
        do_req(48'h4000, 0, 0, 1); do_req(48'h5000, 0, 0, 1);
        chk("wb_evict", {r_evict, r_edirty, r_way}, {1'b1, 1'b1, 2'd0});
        chk("wb_etag", r_etag, 36'h1);
        chk("wb_memw", num_mem_writes, 1);
        chk("wb_cnt", {num_reads, num_writes, num_misses}, {4'd4, 4'd1, 4'd5});

        // write-through: clean eviction
        do_reset();
        do_req(48'h1000, 1, 0, 0);
        chk("wt_wr_memw", num_mem_writes, 1);
        do_req(48'h2000, 0, 0, 0); do_req(48'h3000, 0, 0, 0);
        do_req(48'h4000, 0, 0, 0); do_req(48'h5000, 0, 0, 0);
        chk("wt_evict", {r_evict, r_edirty}, {1'b1, 1'b0});
        chk("wt_etag", r_etag, 36'h1);
        chk("wt_memw", num_mem_writes, 1);

        // response hold, then reset during LOOKUP
        do_reset();
        do_req(48'h1000, 0, 0, 0);
        issue(48'h2000, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("hold_valid_ready", {resp_valid, req_ready}, 2'b10);
            chk("hold_fields", {resp_hit, resp_way, resp_evict, resp_evict_dirty}, {1'b0, 2'd1, 1'b0, 1'b0});
        end
        finish_resp();
        chk("hold_post_valid", resp_valid, 0);
        chk("pre_rst_reads", num_reads, 2);
        req_valid = 1'b1; req_addr = 48'h3000; req_write = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_ready", {req_ready, resp_valid}, 2'b10);
        chk("mid_rst_counters", {num_reads, num_writes, num_hits, num_misses, num_mem_writes}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rst_no_resp", resp_valid, 0);
        do_req(48'h1000, 0, 0, 0);
        chk("mid_rst_refill", {r_hit, r_way, r_evict}, {1'b0, 2'd0, 1'b0});
        chk("mid_rst_reads", num_reads, 1);

        // counter saturation (4-bit counters)
        do_reset();
        for (int i = 0; i < 18; i++) do_req(48'h1040, 0, 1, 0);
        chk("sat_reads", num_reads, 15);
        chk("sat_hits", num_hits, 15);
        chk("sat_misses", num_misses, 1);
        for (int i = 0; i < 18; i++) do_req(48'h1040, 1, 1, 0);
        chk("sat_writes", num_writes, 15);
        chk("sat_memw", num_mem_writes, 15);
        chk("sat_misses2", num_misses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cache_tag_engine.md
CACHE_TAG_ENGINE -- requirements
Module: cache_tag_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 48, byte-address width.
REQ-002 SHALL have parameter BLOCK_BYTES, default 64, power of 2; offset bits OB = log2(BLOCK_BYTES).
REQ-003 SHALL have parameter NUM_SETS, default 64, power of 2; index bits IB = log2(NUM_SETS).
REQ-004 SHALL have parameter NUM_WAYS, default 4, power of 2 and at least 2; way bits WB = log2(NUM_WAYS).
REQ-005 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-006 SHALL have ports, with clock and reset first:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_write  in  1  1 = write, 0 = read.
- replace_policy  in  1  0 = FIFO, 1 = LRU.
- write_policy  in  1  0 = write-through, 1 = write-back.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_hit  out  1  1 = hit.
- resp_way  out  WB  way that was hit or filled.
- resp_evict  out  1  a valid line was evicted.
- resp_evict_tag  out  ADDR_W-OB-IB  tag of the evicted line.
- resp_evict_dirty  out  1  the evicted line was dirty.
- num_reads, num_writes, num_hits, num_misses, num_mem_writes  out  CNT_W each  statistics counters.

Function
REQ-007 SHALL keep per line a tag, a valid bit, a dirty bit and an age field of WB bits; index = req_addr[OB+IB-1:OB]; tag = req_addr[ADDR_W-1:OB+IB].
REQ-008 SHALL implement the FSM IDLE -> LOOKUP -> UPDATE -> RESP -> IDLE. Each state lasts 1 cycle, except that RESP holds until resp_ready=1.
REQ-009 SHALL assert req_ready only in IDLE. A request is accepted on req_valid&&req_ready; addr, write, replace_policy and write_policy SHALL be latched at that edge. Changes to these inputs after acceptance SHALL have no effect on the in-flight request.
REQ-010 SHALL, in LOOKUP, compare the tag against every valid way of the set. A match is a hit. At most one way matches.
REQ-011 SHALL select the victim on a miss as follows: the lowest-numbered invalid way; if every way is valid, the way with the largest age.
REQ-012 SHALL, on a fill in UPDATE (either policy), write the tag, set valid=1, set age 0 on the filled way, and increment the age of every other valid way in the set. Ages within a set SHALL remain distinct and ≤ NUM_WAYS-1.
REQ-013 SHALL, on a hit with LRU, set the hit way's age to 0 and increment every valid way whose age is less than the hit way's old age. On a hit with FIFO, ages SHALL be unchanged.
REQ-014 SHALL allocate on write misses (write-allocate) under both write policies.
REQ-015 SHALL, under write-back, set dirty=1 on any write hit or write fill and dirty=0 on a read fill. Under write-through, dirty SHALL always be written 0.
REQ-016 SHALL drive resp_evict=1 only when the victim was valid, with resp_evict_tag and resp_evict_dirty taken from that victim's contents before replacement.
REQ-017 SHALL hold resp_valid=1 and all resp_* outputs stable from entry to RESP until the cycle after the handshake edge with resp_ready=1.
REQ-018 SHALL update counters once per request in UPDATE:
- num_reads +1 on a read request; num_writes +1 on a write request.
- num_hits +1 on a hit; num_misses +1 on a miss.
- num_mem_writes +1 for each write-through write, plus 1 for each dirty eviction.
REQ-019 SHALL saturate every counter at 2^CNT_W-1 with no wrap-around.
REQ-020 SHALL give a latency of 3 cycles: request accepted at edge N gives resp_valid=1 in cycle N+3. A new request can be accepted at the earliest in the cycle after the response handshake.

Reset
REQ-021 SHALL, on reset=1 at any edge, including mid-operation, return the FSM to IDLE and drop the in-flight request with no counter update.
REQ-022 SHALL, on reset, clear all valid, dirty and age bits and all counters to 0, and drive resp_valid=0, resp_hit=0, resp_evict=0, resp_evict_dirty=0, resp_way=0 and resp_evict_tag=0.
REQ-023 SHALL drive req_ready=1 in the first cycle after reset is deasserted.

Verification
REQ-024 Read 0x1000, then read 0x1010 -> first: miss, way 0; second: hit, way 0; reads=2, hits=1, misses=1.
REQ-025 FIFO: read 0x1000, 0x2000, 0x3000, 0x4000, 0x1000, 0x5000 -> 5th is a hit; 6th evicts tag 0x1 from way 0; a following read of 0x1000 misses.
REQ-026 LRU: same sequence as REQ-025 -> 6th evicts tag 0x2 (way 1); a following read of 0x1000 hits.
REQ-027 Write-back: write 0x1000, then read 0x2000, 0x3000, 0x4000, 0x5000 -> last: resp_evict=1, resp_evict_tag=0x1, resp_evict_dirty=1; num_mem_writes=1. The same sequence under write-through -> resp_evict_dirty=0; num_mem_writes=1.
REQ-028 Hold resp_ready=0 for 4 cycles -> resp_* stable and req_ready=0; then assert reset in LOOKUP of the next request -> all counters 0, and a read of the previously filled address misses.
